// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// dcache-miss refill handshake with watchdog. Optional stall counter under PIPE_STALL_CNT_EN.
module pipe_stall_ctrl #(
   parameter int unsigned TIMEOUT = 64
`ifdef PIPE_STALL_CNT_EN
   ,
   parameter int unsigned CNT_W   = 16
`endif
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             dcache_hit_i,
   input  logic             mem_ack_i,
`ifdef PIPE_STALL_CNT_EN
   input  logic             stall_cnt_clr_i,
   output logic [CNT_W-1:0] stall_cnt_o,
`endif
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             exmem_we_o,
   output logic             memwb_stall_o,
   output logic             mem_refill_req_o,
   output logic             timeout_o
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_MISS  = 2'd1,
      S_DRAIN = 2'd2,
      S_ERR   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               miss_c;
   logic               load_use_c;

   assign miss_c     = (state_q == S_RUN) & mem_req_i & ~dcache_hit_i;
   assign load_use_c = ex_memread_i & (ex_rd_i != 5'd0) &
                       ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i));

   // State and watchdog timer registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_RUN;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // Next-state: refill handshake and watchdog
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         S_RUN: begin
            if (miss_c) begin
               state_d = S_MISS;
               timer_d = '0;
            end
         end
         S_MISS: begin
            if (mem_ack_i) begin
               state_d = S_DRAIN;
            end else begin
               timer_d = timer_q + TMR_W'(1);
               if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                  state_d = S_ERR;
               end
            end
         end
         S_DRAIN: state_d = S_RUN;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_RUN;
      endcase
   end

   // Outputs: combinational so a stall applies in the cycle it is detected
   always_comb begin
      pc_we_o          = 1'b1;
      ifid_we_o        = 1'b1;
      ifid_flush_o     = 1'b0;
      idex_bubble_o    = 1'b0;
      exmem_we_o       = 1'b1;
      memwb_stall_o    = 1'b0;
      mem_refill_req_o = 1'b0;
      timeout_o        = 1'b0;
      if ((state_q != S_RUN) || miss_c) begin
         pc_we_o          = 1'b0;
         ifid_we_o        = 1'b0;
         exmem_we_o       = 1'b0;
         memwb_stall_o    = 1'b1;
         mem_refill_req_o = (state_q == S_MISS);
         timeout_o        = (state_q == S_ERR);
      end else if (load_use_c) begin
         pc_we_o       = 1'b0;
         ifid_we_o     = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o = 1'b1;
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of PC-frozen cycles; clear beats increment
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_cnt_clr_i) begin
         stall_cnt_d = '0;
      end else if (!pc_we_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: vector table, corner-case sequences and random run vs a behavioural model.
module tb_pipe_stall_ctrl;

   localparam int unsigned TMO  = 4;
   localparam int unsigned CW   = 3;
   localparam int          CMAX = 7;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       ex_memread_i;
   logic [4:0] ex_rd_i, id_rs_i, id_rt_i;
   logic       branch_taken_i, mem_req_i, dcache_hit_i, mem_ack_i;
   logic       pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o;
   logic       exmem_we_o, memwb_stall_o, mem_refill_req_o, timeout_o;
`ifdef PIPE_STALL_CNT_EN
   logic          stall_cnt_clr_i;
   logic [CW-1:0] stall_cnt_o;
`endif

   pipe_stall_ctrl #(
      .TIMEOUT(TMO)
`ifdef PIPE_STALL_CNT_EN
      , .CNT_W(CW)
`endif
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ex_memread_i     (ex_memread_i),
      .ex_rd_i          (ex_rd_i),
      .id_rs_i          (id_rs_i),
      .id_rt_i          (id_rt_i),
      .branch_taken_i   (branch_taken_i),
      .mem_req_i        (mem_req_i),
      .dcache_hit_i     (dcache_hit_i),
      .mem_ack_i        (mem_ack_i),
`ifdef PIPE_STALL_CNT_EN
      .stall_cnt_clr_i  (stall_cnt_clr_i),
      .stall_cnt_o      (stall_cnt_o),
`endif
      .pc_we_o          (pc_we_o),
      .ifid_we_o        (ifid_we_o),
      .ifid_flush_o     (ifid_flush_o),
      .idex_bubble_o    (idex_bubble_o),
      .exmem_we_o       (exmem_we_o),
      .memwb_stall_o    (memwb_stall_o),
      .mem_refill_req_o (mem_refill_req_o),
      .timeout_o        (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Output bundle order: pc_we, ifid_we, flush, bubble, exmem_we, memwb_stall, refill_req, timeout
   logic [7:0] outs;
   assign outs = {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o,
                  exmem_we_o, memwb_stall_o, mem_refill_req_o, timeout_o};

   localparam logic [7:0] O_IDLE  = 8'b1100_1000;
   localparam logic [7:0] O_LU    = 8'b0001_1000;
   localparam logic [7:0] O_BR    = 8'b1110_1000;
   localparam logic [7:0] O_STALL = 8'b0000_0100;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: is the pipeline waiting on memory, and for how long
   bit m_dead, m_refill, m_drain;
   int m_wait, m_cnt;
   int seen_stall, seen_req;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_out();
      bit miss, busy, lu;
      miss = !m_dead && !m_refill && !m_drain && mem_req_i && !dcache_hit_i;
      busy = m_dead || m_refill || m_drain || miss;
      lu   = ex_memread_i && (ex_rd_i != 0) && (ex_rd_i == id_rs_i || ex_rd_i == id_rt_i);
      if (busy)                return {5'b00000, 1'b1, m_refill, m_dead};
      else if (lu)             return O_LU;
      else if (branch_taken_i) return O_BR;
      else                     return O_IDLE;
   endfunction

   function automatic void model_step(input logic [7:0] exp);
      bit miss;
      miss = !m_dead && !m_refill && !m_drain && mem_req_i && !dcache_hit_i;
`ifdef PIPE_STALL_CNT_EN
      if (stall_cnt_clr_i)                    m_cnt = 0;
      else if (exp[7] == 1'b0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
`endif
      if (m_dead) begin
      end else if (m_refill) begin
         if (mem_ack_i) begin
            m_refill = 0;
            m_drain  = 1;
         end else begin
            m_wait = m_wait + 1;
            if (m_wait == int'(TMO)) begin
               m_refill = 0;
               m_dead   = 1;
            end
         end
      end else if (m_drain) begin
         m_drain = 0;
      end else if (miss) begin
         m_refill = 1;
         m_wait   = 0;
      end
   endfunction

   task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic req,
                         input logic hit, input logic ack);
      ex_memread_i = mr; ex_rd_i = rd; id_rs_i = rs; id_rt_i = rt;
      branch_taken_i = br; mem_req_i = req; dcache_hit_i = hit; mem_ack_i = ack;
   endtask

   // One clock: inputs already driven after a negedge; check, then advance model across posedge
   task automatic tick(input string nm);
      logic [7:0] exp;
      #1;
      exp = model_out();
      check(nm, 32'(outs), 32'(exp));
`ifdef PIPE_STALL_CNT_EN
      check({nm, "_cnt"}, 32'(stall_cnt_o), 32'(m_cnt));
`endif
      if (!pc_we_o)         seen_stall++;
      if (mem_refill_req_o) seen_req++;
      model_step(exp);
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
`ifdef PIPE_STALL_CNT_EN
      stall_cnt_clr_i = 1'b0;
`endif
      #1;
      check("reset_outs", 32'(outs), 32'(O_IDLE));
`ifdef PIPE_STALL_CNT_EN
      check("reset_cnt", 32'(stall_cnt_o), 32'd0);
`endif
      @(negedge clk_i);
      rst_i = 1'b1;
      m_dead = 0; m_refill = 0; m_drain = 0; m_wait = 0; m_cnt = 0;
      seen_stall = 0; seen_req = 0;
   endtask

   typedef struct {
      string      nm;
      logic       mr;
      logic [4:0] rd, rs, rt;
      logic       br, req, hit, ack;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench timeout");
   end

   initial begin
      vecs[0]  = '{"idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_IDLE};
      vecs[1]  = '{"lu_rs",       1, 5'd5, 5'd5, 5'd9, 0, 0, 1, 0, O_LU};
      vecs[2]  = '{"lu_rt",       1, 5'd7, 5'd3, 5'd7, 0, 0, 1, 0, O_LU};
      vecs[3]  = '{"lu_r0",       1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_IDLE};
      vecs[4]  = '{"no_load",     0, 5'd5, 5'd5, 5'd5, 0, 0, 1, 0, O_IDLE};
      vecs[5]  = '{"branch",      0, 5'd0, 5'd1, 5'd2, 1, 0, 1, 0, O_BR};
      vecs[6]  = '{"br_plus_lu",  1, 5'd4, 5'd4, 5'd2, 1, 0, 1, 0, O_LU};
      vecs[7]  = '{"hit",         0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, O_IDLE};
      vecs[8]  = '{"miss",        0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_STALL};
      vecs[9]  = '{"miss_lu_br",  1, 5'd6, 5'd6, 5'd6, 1, 1, 0, 0, O_STALL};
      vecs[10] = '{"ack_in_run",  0, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1, O_BR};

      rst_i = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
`ifdef PIPE_STALL_CNT_EN
      stall_cnt_clr_i = 1'b0;
`endif
      m_dead = 0; m_refill = 0; m_drain = 0; m_wait = 0; m_cnt = 0;

      // Single-cycle table, fresh state each entry
      for (int i = 0; i < 11; i++) begin
         do_reset();
         set_in(vecs[i].mr, vecs[i].rd, vecs[i].rs, vecs[i].rt,
                vecs[i].br, vecs[i].req, vecs[i].hit, vecs[i].ack);
         #1;
         check(vecs[i].nm, 32'(outs), 32'(vecs[i].exp));
      end

      // Miss with ack on the 3rd MISS cycle
      do_reset();
      set_in(0, 0, 0, 0, 0, 1, 0, 0); tick("ack3_detect");
      set_in(0, 0, 0, 0, 0, 0, 1, 0); tick("ack3_m1");
      tick("ack3_m2");
      mem_ack_i = 1'b1;               tick("ack3_m3");
      mem_ack_i = 1'b0;               tick("ack3_drain");
      tick("ack3_run");
      check("ack3_stall_cycles", 32'(seen_stall), 32'd5);
      check("ack3_req_cycles", 32'(seen_req), 32'd3);
`ifdef PIPE_STALL_CNT_EN
      check("ack3_cnt", 32'(stall_cnt_o), 32'd5);
`endif

      // Watchdog expiry is sticky
      do_reset();
      set_in(0, 0, 0, 0, 0, 1, 0, 0); tick("tmo_detect");
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < int'(TMO); i++) tick("tmo_miss");
      #1;
      check("tmo_flag", 32'(timeout_o), 32'd1);
      mem_ack_i = 1'b1; tick("tmo_ack1"); tick("tmo_ack2");
      mem_ack_i = 1'b0; tick("tmo_hold");
      #1;
      check("tmo_still", 32'(timeout_o), 32'd1);
      check("tmo_req_cycles", 32'(seen_req), 32'(TMO));

      // Reset in the middle of a refill
      do_reset();
      set_in(0, 0, 0, 0, 0, 1, 0, 0); tick("rmid_detect");
      set_in(0, 0, 0, 0, 0, 0, 1, 0); tick("rmid_m1");
      #1;
      check("rmid_req_before", 32'(mem_refill_req_o), 32'd1);
      rst_i = 1'b0;
      #1;
      check("rmid_req_async", 32'(mem_refill_req_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      m_dead = 0; m_refill = 0; m_drain = 0; m_wait = 0; m_cnt = 0;
      #1;
      check("rmid_pc_we", 32'(pc_we_o), 32'd1);
      check("rmid_timeout", 32'(timeout_o), 32'd0);
      @(negedge clk_i);
      tick("rmid_run");

`ifdef PIPE_STALL_CNT_EN
      // Counter saturation and clear-wins
      do_reset();
      set_in(1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) tick("sat_lu");
      #1;
      check("sat_cnt", 32'(stall_cnt_o), 32'(CMAX));
      stall_cnt_clr_i = 1'b1; tick("sat_clr");
      stall_cnt_clr_i = 1'b0;
      #1;
      check("clr_cnt", 32'(stall_cnt_o), 32'd0);
`endif

      // Random run against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ((m_dead && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
            do_reset();
         end
         set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
`ifdef PIPE_STALL_CNT_EN
         stall_cnt_clr_i = 1'($urandom_range(0, 15) == 0);
`endif
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
